led_pattern_monitor: RTL and testbench
======================================

# led_pattern_monitor

Receive-side checker for the LED blink pattern produced by the on-chip counter/LED driver. It samples one LED line and measures every high-run and low-run length in clock cycles. It locks once the measured pattern matches the expected duty profile for a number of consecutive periods, then raises a sticky alarm on any deviation. It sits beside the counter in the hardware-security test harness as a tamper or trojan detector for the indicator path.

## Interface
- CNT_W, 8, width of run-length counters and length outputs
- EXP_HIGH, 6, expected high-run length in cycles
- EXP_LOW, 250, expected low-run length in cycles; must be < 2^CNT_W-1
- TOL, 1, allowed absolute deviation per run, in cycles
- LOCK_PERIODS, 4, consecutive good periods required to lock, range 1..15

- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- enable  input  1  monitor run enable
- led_in  input  1  LED line under test, already synchronous to clk
- alarm_clr  input  1  one-cycle pulse that clears alarm
- locked  output  1  pattern matched for LOCK_PERIODS consecutive periods
- alarm  output  1  sticky; deviation or stuck line detected while locked
- meas_valid  output  1  one-cycle pulse when a full period has been measured
- stuck  output  1  one-cycle pulse when a run counter saturates
- last_high_len  output  CNT_W  high-run length of the last completed period
- last_low_len  output  CNT_W  low-run length of the last completed period
- good_periods  output  8  count of good periods since reset; wraps 255->0

## Operation
- led_prev register with reset value 0. rise = led_in & ~led_prev; fall = ~led_in & led_prev.
- States: IDLE, SYNC, MEAS_HIGH, MEAS_LOW.
- IDLE: enable=1 moves to SYNC. Any state with enable=0 moves to IDLE, clears run_cnt, good_cnt and locked. alarm holds its value.
- SYNC: waits for rise. On rise, run_cnt<=1 and the state moves to MEAS_HIGH. The partial high run seen at sync is never measured.
- MEAS_HIGH: while led_in=1, run_cnt increments. On fall, high_len<=run_cnt, run_cnt<=1, and the state moves to MEAS_LOW.
- MEAS_LOW: while led_in=0, run_cnt increments. On rise, last_high_len<=high_len, last_low_len<=run_cnt, meas_valid<=1, the period is evaluated, run_cnt<=1, and the state moves to MEAS_HIGH.
- Good period: |high_len-EXP_HIGH|<=TOL and |run_cnt-EXP_LOW|<=TOL. Compute with CNT_W+1-bit signed differences; no wrap is allowed.
- Good period effects:
  - good_cnt increments, saturating at LOCK_PERIODS.
  - good_periods increments.
  - locked<=1 on the period where good_cnt reaches LOCK_PERIODS.
- Bad period effects: good_cnt<=0 and locked<=0. If locked was 1, alarm<=1.
- Stuck: run_cnt reaching 2^CNT_W-1 in MEAS_HIGH or MEAS_LOW is a bad period.
  - stuck pulses.
  - last_* registers are not updated and meas_valid is not asserted.
  - The state moves to SYNC.
- alarm_clr clears alarm. If alarm_clr and an alarm set occur in the same cycle, the set wins.
- run_cnt saturates and never wraps.

## Timing
- Reset values: every output is 0. State is IDLE, and led_prev, run_cnt and good_cnt are 0.
- Length definition: a line high for N clock samples gives high_len=N. The same rule applies to low runs.
- The clock edge that samples the terminating rise registers meas_valid, last_*, locked, alarm and good_periods. All are visible one cycle later.
- stuck asserts on the edge where run_cnt becomes saturated.
- rst takes priority over enable and alarm_clr. Reset mid-period discards the partial measurement.
- enable dropping mid-period discards the partial measurement. Re-enabling always passes through SYNC.
- A rise in the same cycle that enable goes to 1 is ignored, because the monitor is still in IDLE during that cycle.

## Structure
- Shared package holds:
  - the state enum (IDLE, SYNC, MEAS_HIGH, MEAS_LOW);
  - the default constants EXP_HIGH, EXP_LOW, TOL and LOCK_PERIODS, so the counter/LED driver and this monitor agree on the pattern.
- One sub-module, run_len_counter: a saturating CNT_W counter with load-1, increment and saturated flag. It is natural and reusable.
- The tolerance comparator stays inline.

## Test plan
- Reset, then enable, then 5 periods of 6 high / 250 low:
  - meas_valid pulses 4 times, because the first period only syncs;
  - locked=1 after the 4th meas_valid;
  - last_high_len=6, last_low_len=250, good_periods=4.
- Locked, then one period of 8 high / 250 low:
  - alarm=1 and locked=0 one cycle after the rise;
  - last_high_len=8;
  - 4 further good periods relock, and alarm stays 1.
- Periods of 7/249 and 5/251 are good; a period of 6/252 is bad.
- Locked, then led_in held 1 for 260 cycles:
  - stuck pulses when run_cnt hits 255;
  - alarm=1, the state returns to SYNC, and last_* are unchanged.
- alarm_clr coinciding with a bad-period evaluation leaves alarm=1; alarm_clr alone clears it.
- rst or enable=0 mid-low-run: locked=0, no meas_valid, and the next complete period is measured correctly.

Source files
------------

// File: rtl/led_pattern_monitor_pkg.sv
// Shared definitions for the LED blink pattern: monitor state encoding and the
// default duty profile that both the LED driver and the monitor are built against.
package led_pattern_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    localparam int DEF_CNT_W        = 8;
    localparam int DEF_EXP_HIGH     = 6;
    localparam int DEF_EXP_LOW      = 250;
    localparam int DEF_TOL          = 1;
    localparam int DEF_LOCK_PERIODS = 4;

endpackage

// File: rtl/led_pattern_monitor_if.sv
// Control and status bundle of the LED pattern monitor; master drives the LED
// line and controls, slave (the monitor) returns lock/alarm/measurement status.
interface led_pattern_monitor_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             led_in;
    logic             alarm_clr;
    logic             locked;
    logic             alarm;
    logic             meas_valid;
    logic             stuck;
    logic [CNT_W-1:0] last_high_len;
    logic [CNT_W-1:0] last_low_len;
    logic [7:0]       good_periods;

    modport master (
        output enable, led_in, alarm_clr,
        input  locked, alarm, meas_valid, stuck,
        input  last_high_len, last_low_len, good_periods
    );

    modport slave (
        input  enable, led_in, alarm_clr,
        output locked, alarm, meas_valid, stuck,
        output last_high_len, last_low_len, good_periods
    );
endinterface

// File: rtl/led_pattern_monitor_run_len_counter.sv
// Saturating run-length counter: clear, load-to-1 and increment, with a flag
// marking the increment that drives the count into saturation.
module run_len_counter
    import led_pattern_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat_hit
);
    localparam logic [CNT_W-1:0] MAX  = '1;
    localparam logic [CNT_W-1:0] NEAR = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    assign sat_hit = inc & ~clr & ~load & (cnt == NEAR);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ONE;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + ONE;
        end
    end
endmodule

// File: rtl/led_pattern_monitor.sv
// Receive-side LED blink checker: measures high/low run lengths, locks onto the
// expected duty profile and raises a sticky alarm on any deviation while locked.
module led_pattern_monitor
    import led_pattern_monitor_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int EXP_HIGH     = DEF_EXP_HIGH,
    parameter int EXP_LOW      = DEF_EXP_LOW,
    parameter int TOL          = DEF_TOL,
    parameter int LOCK_PERIODS = DEF_LOCK_PERIODS
) (
    input logic                  clk,
    input logic                  rst,
    led_pattern_monitor_if.slave bus
);
    localparam logic signed [CNT_W:0] EXP_HIGH_S = (CNT_W+1)'(EXP_HIGH);
    localparam logic signed [CNT_W:0] EXP_LOW_S  = (CNT_W+1)'(EXP_LOW);
    localparam logic signed [CNT_W:0] TOL_S      = (CNT_W+1)'(TOL);
    localparam logic [3:0]            LOCK_N     = 4'(LOCK_PERIODS);

    state_t state, state_nxt;

    logic             led_prev;
    logic             rise, fall;
    logic             cnt_clr, cnt_load, cnt_inc;
    logic             cap_high, eval;
    logic             sat_hit;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] high_len;
    logic [3:0]       good_cnt;

    logic signed [CNT_W:0] dh, dl, dh_abs, dl_abs;
    logic                  good, good_ev, bad_ev;

    logic             locked_q, alarm_q, meas_valid_q, stuck_q;
    logic [CNT_W-1:0] last_high_q, last_low_q;
    logic [7:0]       good_periods_q;

    assign rise = bus.led_in & ~led_prev;
    assign fall = ~bus.led_in & led_prev;

    run_len_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .load    (cnt_load),
        .inc     (cnt_inc),
        .cnt     (run_cnt),
        .sat_hit (sat_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!bus.enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      state_nxt = SYNC;
                SYNC:      if (rise) state_nxt = MEAS_HIGH;
                MEAS_HIGH: begin
                    if (fall)         state_nxt = MEAS_LOW;
                    else if (sat_hit) state_nxt = SYNC;
                end
                MEAS_LOW: begin
                    if (rise)         state_nxt = MEAS_HIGH;
                    else if (sat_hit) state_nxt = SYNC;
                end
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        cap_high = 1'b0;
        eval     = 1'b0;
        if (!bus.enable) begin
            cnt_clr = 1'b1;
        end else begin
            case (state)
                SYNC: cnt_load = rise;
                MEAS_HIGH: begin
                    if (fall) begin
                        cnt_load = 1'b1;
                        cap_high = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        cnt_load = 1'b1;
                        eval     = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Signed one-bit-wider differences so a short run never wraps into a pass.
    assign dh = $signed({1'b0, high_len}) - EXP_HIGH_S;
    assign dl = $signed({1'b0, run_cnt}) - EXP_LOW_S;

    always_comb begin
        dh_abs  = dh[CNT_W] ? -dh : dh;
        dl_abs  = dl[CNT_W] ? -dl : dl;
        good    = (dh_abs <= TOL_S) && (dl_abs <= TOL_S);
        good_ev = eval & good;
        bad_ev  = (eval & ~good) | sat_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_prev       <= 1'b0;
            high_len       <= '0;
            good_cnt       <= '0;
            locked_q       <= 1'b0;
            alarm_q        <= 1'b0;
            meas_valid_q   <= 1'b0;
            stuck_q        <= 1'b0;
            last_high_q    <= '0;
            last_low_q     <= '0;
            good_periods_q <= '0;
        end else begin
            led_prev     <= bus.led_in;
            meas_valid_q <= eval;
            stuck_q      <= sat_hit;

            if (cap_high) begin
                high_len <= run_cnt;
            end
            if (eval) begin
                last_high_q <= high_len;
                last_low_q  <= run_cnt;
            end

            if (!bus.enable) begin
                good_cnt <= '0;
                locked_q <= 1'b0;
            end else if (good_ev) begin
                good_periods_q <= good_periods_q + 8'd1;
                if (good_cnt != LOCK_N) begin
                    good_cnt <= good_cnt + 4'd1;
                end
                if (good_cnt >= LOCK_N - 4'd1) begin
                    locked_q <= 1'b1;
                end
            end else if (bad_ev) begin
                good_cnt <= '0;
                locked_q <= 1'b0;
            end

            // A deviation seen while locked outranks a coincident clear.
            if (bad_ev && locked_q) begin
                alarm_q <= 1'b1;
            end else if (bus.alarm_clr) begin
                alarm_q <= 1'b0;
            end
        end
    end

    assign bus.locked        = locked_q;
    assign bus.alarm         = alarm_q;
    assign bus.meas_valid    = meas_valid_q;
    assign bus.stuck         = stuck_q;
    assign bus.last_high_len = last_high_q;
    assign bus.last_low_len  = last_low_q;
    assign bus.good_periods  = good_periods_q;
endmodule

// File: tb/tb_led_pattern_monitor.sv
// Directed bench for led_pattern_monitor: a run-length model of the blink rules
// is checked against the DUT every cycle, plus hand-computed checkpoints.
module tb_led_pattern_monitor;
    localparam int EXP_H = 6;
    localparam int EXP_L = 250;
    localparam int TOLR  = 1;
    localparam int LOCKN = 4;
    localparam int SAT   = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic led_in = 1'b0;
    logic alarm_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int mv_count = 0;
    int st_count = 0;
    int mv0, st0;

    led_pattern_monitor_if #(.CNT_W(8)) bus ();

    assign bus.enable    = enable;
    assign bus.led_in    = led_in;
    assign bus.alarm_clr = alarm_clr;

    led_pattern_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks the current run length as a plain integer and judges each
    // completed high+low pair against the duty profile.
    bit   m_active, m_synced, m_prev;
    int   m_len, m_hi, m_streak;
    logic m_locked, m_alarm, m_mv, m_stuck;
    logic [7:0] m_gp;
    int   m_last_h, m_last_l;
    bit   m_good, m_bad, m_set;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    initial begin
        m_active = 0; m_synced = 0; m_prev = 0; m_len = 0; m_hi = 0; m_streak = 0;
        m_locked = 0; m_alarm = 0; m_mv = 0; m_stuck = 0; m_gp = 0;
        m_last_h = 0; m_last_l = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_active = 0; m_synced = 0; m_prev = 0; m_len = 0; m_hi = 0; m_streak = 0;
                m_locked = 0; m_alarm = 0; m_mv = 0; m_stuck = 0; m_gp = 0;
                m_last_h = 0; m_last_l = 0;
            end else begin
                m_mv = 0; m_stuck = 0; m_good = 0; m_bad = 0; m_set = 0;
                if (!enable) begin
                    m_active = 0; m_synced = 0; m_streak = 0; m_locked = 0;
                end else if (!m_active) begin
                    m_active = 1; m_synced = 0;
                end else if (!m_synced) begin
                    if (led_in && !m_prev) begin
                        m_synced = 1; m_len = 1;
                    end
                end else if (led_in == m_prev) begin
                    m_len++;
                    if (m_len == SAT) begin
                        m_stuck = 1; m_bad = 1; m_synced = 0;
                    end
                end else if (!led_in) begin
                    m_hi = m_len; m_len = 1;
                end else begin
                    m_last_h = m_hi; m_last_l = m_len; m_mv = 1;
                    if (iabs(m_hi - EXP_H) <= TOLR && iabs(m_len - EXP_L) <= TOLR) m_good = 1;
                    else m_bad = 1;
                    m_len = 1;
                end
                if (m_good) begin
                    m_gp++;
                    if (m_streak < LOCKN) m_streak++;
                    if (m_streak == LOCKN) m_locked = 1;
                end
                if (m_bad) begin
                    if (m_locked) m_set = 1;
                    m_streak = 0; m_locked = 0;
                end
                if (m_set) m_alarm = 1;
                else if (alarm_clr) m_alarm = 0;
                m_prev = led_in;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("locked", bus.locked, m_locked);
            chk("alarm", bus.alarm, m_alarm);
            chk("meas_valid", bus.meas_valid, m_mv);
            chk("stuck", bus.stuck, m_stuck);
            chk("last_high_len", bus.last_high_len, m_last_h);
            chk("last_low_len", bus.last_low_len, m_last_l);
            chk("good_periods", bus.good_periods, m_gp);
            if (bus.meas_valid === 1'b1) mv_count++;
            if (bus.stuck === 1'b1) st_count++;
        end
    end

    task automatic run(input logic lvl, input int n);
        led_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic period(input int h, input int l);
        run(1'b1, h);
        run(1'b0, l);
    endtask

    task automatic clr_pulse_low();
        alarm_clr = 1'b1;
        run(1'b0, 1);
        alarm_clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_locked", bus.locked, 0);
        chk("rst_alarm", bus.alarm, 0);
        chk("rst_last_high", bus.last_high_len, 0);
        chk("rst_good_periods", bus.good_periods, 0);
        rst = 1'b0;
        enable = 1'b1;
        run(1'b0, 4);

        // Lock on five nominal periods; the first only synchronises.
        repeat (5) period(6, 250);
        chk("lock_mv_count", mv_count, 4);
        chk("lock_locked", bus.locked, 1);
        chk("lock_last_high", bus.last_high_len, 6);
        chk("lock_last_low", bus.last_low_len, 250);
        chk("lock_good_periods", bus.good_periods, 4);

        // Long high run while locked raises the alarm, then relock.
        run(1'b1, 8);
        chk("p8_gp", bus.good_periods, 5);
        run(1'b0, 250);
        run(1'b1, 6);
        chk("dev_alarm", bus.alarm, 1);
        chk("dev_locked", bus.locked, 0);
        chk("dev_last_high", bus.last_high_len, 8);
        run(1'b0, 250);
        repeat (3) period(6, 250);
        run(1'b1, 6);
        chk("relock_locked", bus.locked, 1);
        chk("relock_alarm", bus.alarm, 1);
        chk("relock_gp", bus.good_periods, 9);
        run(1'b0, 250);

        // Tolerance edges.
        period(7, 249);
        period(5, 251);
        run(1'b1, 6);
        chk("tol_gp", bus.good_periods, 12);
        chk("tol_locked", bus.locked, 1);
        chk("tol_last_high", bus.last_high_len, 5);
        chk("tol_last_low", bus.last_low_len, 251);
        run(1'b0, 252);
        run(1'b1, 6);
        chk("tol_bad_locked", bus.locked, 0);
        chk("tol_bad_last_low", bus.last_low_len, 252);
        chk("tol_bad_gp", bus.good_periods, 12);

        // Clear alone mid-low, then relock with alarm clear.
        run(1'b0, 100);
        clr_pulse_low();
        run(1'b0, 149);
        chk("clr_alarm", bus.alarm, 0);
        repeat (3) period(6, 250);
        run(1'b1, 6);
        chk("relock2_locked", bus.locked, 1);
        chk("relock2_alarm", bus.alarm, 0);

        // Stuck-high line: 260 high samples in total.
        st0 = st_count;
        run(1'b1, 254);
        chk("stuck_pulses", st_count - st0, 1);
        chk("stuck_alarm", bus.alarm, 1);
        chk("stuck_locked", bus.locked, 0);
        chk("stuck_last_high", bus.last_high_len, 6);
        chk("stuck_last_low", bus.last_low_len, 250);
        run(1'b0, 10);
        clr_pulse_low();
        chk("stuck_clr_alarm", bus.alarm, 0);
        repeat (4) period(6, 250);
        run(1'b1, 6);
        chk("relock3_locked", bus.locked, 1);

        // Clear coinciding with a bad evaluation: set wins.
        run(1'b0, 252);
        alarm_clr = 1'b1;
        run(1'b1, 1);
        alarm_clr = 1'b0;
        run(1'b1, 5);
        chk("clr_vs_set_alarm", bus.alarm, 1);
        chk("clr_vs_set_locked", bus.locked, 0);
        run(1'b0, 50);
        clr_pulse_low();
        run(1'b0, 199);
        chk("clr2_alarm", bus.alarm, 0);
        repeat (3) period(6, 250);
        run(1'b1, 6);
        chk("relock4_locked", bus.locked, 1);

        // Enable drop mid-low; re-enable on a rising edge that must be ignored.
        run(1'b0, 100);
        enable = 1'b0;
        run(1'b0, 5);
        chk("dis_locked", bus.locked, 0);
        mv0 = mv_count;
        enable = 1'b1;
        period(5, 251);
        period(7, 249);
        run(1'b1, 6);
        chk("reen_mv_delta", mv_count - mv0, 1);
        chk("reen_last_high", bus.last_high_len, 7);
        chk("reen_last_low", bus.last_low_len, 249);

        // Reset mid-low with enable held high.
        run(1'b0, 100);
        rst = 1'b1;
        run(1'b0, 2);
        rst = 1'b0;
        chk("mrst_locked", bus.locked, 0);
        chk("mrst_last_high", bus.last_high_len, 0);
        chk("mrst_gp", bus.good_periods, 0);
        run(1'b0, 3);
        period(5, 251);
        period(6, 250);
        run(1'b1, 6);
        chk("mrst_last_high2", bus.last_high_len, 6);
        chk("mrst_last_low2", bus.last_low_len, 250);
        chk("mrst_gp2", bus.good_periods, 2);
        run(1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
